// File: rtl/dma_addr_gen_if.sv
// Sequencer-side bus of the DMA address generator: instruction,
// load data and count enable in; read data, address and flags out.
interface dma_addr_gen_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       instr;
    logic [WIDTH-1:0] din;
    logic             cnt_en;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] addr;
    logic             done;
    logic             halted;

    modport master (
        output instr, din, cnt_en,
        input  dout, addr, done, halted
    );

    modport slave (
        input  instr, din, cnt_en,
        output dout, addr, done, halted
    );
endinterface

// File: rtl/dma_addr_gen.sv
// DMA address generator: address/word-count registers and counters,
// control register, look-ahead terminal count and optional auto-stop.
module dma_addr_gen #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    dma_addr_gen_if.slave bus
);
    typedef enum logic [2:0] {
        WRCR   = 3'd0,
        RDCR   = 3'd1,
        RDWC   = 3'd2,
        RDAC   = 3'd3,
        REINIT = 3'd4,
        LDAD   = 3'd5,
        LDWC   = 3'd6,
        ENCT   = 3'd7
    } instr_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    instr_t           op;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] ac;
    logic [WIDTH-1:0] wcr;
    logic [WIDTH-1:0] wc;
    logic             halted;

    logic [1:0]       mode;
    logic             addr_dec;
    logic             auto_stop;
    logic             cnt;
    logic             done;
    logic [3:0]       din4;
    logic [WIDTH-1:0] ctrl_rd;
    logic [WIDTH-1:0] wc_inc;
    logic [WIDTH-1:0] wc_next;
    logic [WIDTH-1:0] ac_next;
    logic [WIDTH-1:0] dout;

    assign op        = instr_t'(bus.instr);
    assign mode      = ctrl[1:0];
    assign addr_dec  = ctrl[2];
    assign auto_stop = ctrl[3];
    assign cnt       = (op == ENCT) && bus.cnt_en && !halted;
    assign wc_inc    = wc + ONE;
    assign ac_next   = addr_dec ? ac - ONE : ac + ONE;

    // Control register is 4 bits wide regardless of WIDTH.
    generate
        if (WIDTH > 4) begin : g_wide
            assign din4    = bus.din[3:0];
            assign ctrl_rd = {{(WIDTH-4){1'b0}}, ctrl};
        end else if (WIDTH == 4) begin : g_four
            assign din4    = bus.din;
            assign ctrl_rd = ctrl;
        end else begin : g_narrow
            assign din4    = {{(4-WIDTH){1'b0}}, bus.din};
            assign ctrl_rd = ctrl[WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        wc_next = wc;
        unique case (mode)
            2'b00:   wc_next = wc - ONE;
            2'b10:   wc_next = wc;
            default: wc_next = wc_inc;
        endcase
    end

    // Look-ahead: flag the cycle in which the final count executes.
    always_comb begin
        done = 1'b0;
        unique case (mode)
            2'b00:   done = cnt ? (wc == ONE) : (wc == '0);
            2'b01:   done = cnt ? (wc_inc == wcr) : (wc == wcr);
            2'b10:   done = (wc == ac);
            default: done = 1'b0;
        endcase
    end

    always_comb begin
        dout = '0;
        case (op)
            RDCR:    dout = ctrl_rd;
            RDWC:    dout = wc;
            RDAC:    dout = ac;
            default: dout = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl   <= '0;
            ar     <= '0;
            ac     <= '0;
            wcr    <= '0;
            wc     <= '0;
            halted <= 1'b0;
        end else begin
            case (op)
                WRCR: begin
                    ctrl   <= din4;
                    halted <= 1'b0;
                end
                REINIT: begin
                    ac     <= ar;
                    wc     <= mode[0] ? '0 : wcr;
                    halted <= 1'b0;
                end
                LDAD: begin
                    ar     <= bus.din;
                    ac     <= bus.din;
                    halted <= 1'b0;
                end
                LDWC: begin
                    wcr    <= bus.din;
                    wc     <= mode[0] ? '0 : bus.din;
                    halted <= 1'b0;
                end
                ENCT: begin
                    if (cnt) begin
                        ac <= ac_next;
                        wc <= wc_next;
                        if (done && auto_stop)
                            halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dout   = dout;
    assign bus.addr   = ac;
    assign bus.done   = done;
    assign bus.halted = halted;
endmodule

// File: tb/tb_dma_addr_gen.sv
// Directed bench for dma_addr_gen (WIDTH=8): inputs change 1 time unit
// after the rising edge, outputs are sampled 3 time units after it.
module tb_dma_addr_gen;
    localparam int W = 8;

    localparam logic [2:0] WRCR   = 3'd0;
    localparam logic [2:0] RDCR   = 3'd1;
    localparam logic [2:0] RDWC   = 3'd2;
    localparam logic [2:0] RDAC   = 3'd3;
    localparam logic [2:0] REINIT = 3'd4;
    localparam logic [2:0] LDAD   = 3'd5;
    localparam logic [2:0] LDWC   = 3'd6;
    localparam logic [2:0] ENCT   = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dma_addr_gen_if #(.WIDTH(W)) bus ();

    dma_addr_gen #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [2:0] i, input logic [W-1:0] d,
                        input logic e);
        @(posedge clk);
        #1;
        bus.instr  = i;
        bus.din    = d;
        bus.cnt_en = e;
        #2;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.instr  = RDCR;
        bus.din    = '0;
        bus.cnt_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("rst_addr", bus.addr, 8'h00);
        chk("rst_halted", {7'd0, bus.halted}, 8'h00);
        chk("rst_done", {7'd0, bus.done}, 8'h01);
        chk("rst_dout", bus.dout, 8'h00);

        // Mode 00 countdown
        step(LDWC, 8'h03, 1'b0);
        step(ENCT, 8'h00, 1'b1);
        chk("m0_done1", {7'd0, bus.done}, 8'h00);
        step(ENCT, 8'h00, 1'b1);
        chk("m0_done2", {7'd0, bus.done}, 8'h00);
        step(ENCT, 8'h00, 1'b1);
        chk("m0_done3", {7'd0, bus.done}, 8'h01);
        step(RDWC, 8'h00, 1'b0);
        chk("m0_wc0", bus.dout, 8'h00);
        chk("m0_idle_done", {7'd0, bus.done}, 8'h01);
        step(ENCT, 8'h00, 1'b1);
        chk("m0_done4", {7'd0, bus.done}, 8'h00);
        step(RDWC, 8'h00, 1'b0);
        chk("m0_wrap", bus.dout, 8'hFF);
        chk("m0_wrap_done", {7'd0, bus.done}, 8'h00);
        chk("m0_addr", bus.addr, 8'h04);

        // Mode 01 with auto-stop
        step(WRCR, 8'h09, 1'b0);
        step(LDAD, 8'h10, 1'b0);
        step(LDWC, 8'h04, 1'b0);
        step(ENCT, 8'h00, 1'b1);
        chk("m1_done1", {7'd0, bus.done}, 8'h00);
        step(ENCT, 8'h00, 1'b1);
        step(ENCT, 8'h00, 1'b1);
        chk("m1_done3", {7'd0, bus.done}, 8'h00);
        step(ENCT, 8'h00, 1'b1);
        chk("m1_done4", {7'd0, bus.done}, 8'h01);
        chk("m1_nohalt4", {7'd0, bus.halted}, 8'h00);
        step(ENCT, 8'h00, 1'b1);
        chk("m1_halted", {7'd0, bus.halted}, 8'h01);
        chk("m1_done_hold", {7'd0, bus.done}, 8'h01);
        chk("m1_addr5", bus.addr, 8'h14);
        step(ENCT, 8'h00, 1'b1);
        chk("m1_addr6", bus.addr, 8'h14);
        step(RDWC, 8'h00, 1'b0);
        chk("m1_wc", bus.dout, 8'h04);
        step(REINIT, 8'h00, 1'b0);
        step(RDAC, 8'h00, 1'b0);
        chk("m1_re_addr", bus.addr, 8'h10);
        chk("m1_re_ac", bus.dout, 8'h10);
        chk("m1_re_halt", {7'd0, bus.halted}, 8'h00);
        step(RDWC, 8'h00, 1'b0);
        chk("m1_re_wc", bus.dout, 8'h00);
        chk("m1_re_done", {7'd0, bus.done}, 8'h00);

        // Address decrement wrap
        step(WRCR, 8'h04, 1'b0);
        step(LDAD, 8'h01, 1'b0);
        step(ENCT, 8'h00, 1'b1);
        chk("dec_a1", bus.addr, 8'h01);
        step(ENCT, 8'h00, 1'b1);
        chk("dec_a0", bus.addr, 8'h00);
        step(RDCR, 8'h00, 1'b0);
        chk("dec_aff", bus.addr, 8'hFF);
        chk("dec_ctrl", bus.dout, 8'h04);

        // Mode 10 compare
        step(WRCR, 8'h02, 1'b0);
        step(LDWC, 8'h23, 1'b0);
        step(LDAD, 8'h20, 1'b0);
        step(ENCT, 8'h00, 1'b1);
        chk("m2_done20", {7'd0, bus.done}, 8'h00);
        step(ENCT, 8'h00, 1'b1);
        step(ENCT, 8'h00, 1'b1);
        chk("m2_done22", {7'd0, bus.done}, 8'h00);
        step(RDWC, 8'h00, 1'b0);
        chk("m2_done23", {7'd0, bus.done}, 8'h01);
        chk("m2_wc", bus.dout, 8'h23);
        chk("m2_addr", bus.addr, 8'h23);

        // cnt_en low and reads
        step(WRCR, 8'h00, 1'b0);
        step(LDWC, 8'h01, 1'b0);
        step(ENCT, 8'h00, 1'b0);
        chk("en0_done", {7'd0, bus.done}, 8'h00);
        step(ENCT, 8'h00, 1'b0);
        step(RDWC, 8'h00, 1'b0);
        chk("en0_wc", bus.dout, 8'h01);
        chk("en0_addr", bus.addr, 8'h23);
        step(WRCR, 8'h0B, 1'b0);
        step(RDCR, 8'h00, 1'b0);
        chk("rd_ctrl", bus.dout, 8'h0B);
        chk("m3_done", {7'd0, bus.done}, 8'h00);
        step(RDAC, 8'h00, 1'b0);
        chk("rd_ac", bus.dout, 8'h23);
        step(ENCT, 8'h00, 1'b0);
        chk("dout_enct", bus.dout, 8'h00);

        // Reset mid-count
        step(WRCR, 8'h00, 1'b0);
        step(LDAD, 8'h50, 1'b0);
        step(LDWC, 8'h05, 1'b0);
        step(ENCT, 8'h00, 1'b1);
        step(ENCT, 8'h00, 1'b1);
        chk("mid_addr", bus.addr, 8'h51);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.instr  = RDCR;
        bus.cnt_en = 1'b0;
        #2;
        chk("rst2_addr", bus.addr, 8'h00);
        chk("rst2_halted", {7'd0, bus.halted}, 8'h00);
        chk("rst2_done", {7'd0, bus.done}, 8'h01);
        chk("rst2_ctrl", bus.dout, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dma_addr_gen.md
# dma_addr_gen

Parametrised DMA address generator: address register/counter, word-count register/counter, control register and terminal-count (`done`) logic in one synchronous block. It sits between the DMA sequencer, which issues one 3-bit instruction per clock, and the memory address bus. It generalises the fixed 8-bit terminal-count comparator to any `WIDTH`. It adds register storage, counting, address inc/dec and an optional auto-stop on terminal count.

## Interface
- `WIDTH`, 8, width of data, address and word-count paths (≥2)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr`  in  3  instruction executed this cycle (encoding below)
- `din`  in  WIDTH  load data for WRCR/LDAD/LDWC (WRCR uses `din[3:0]`)
- `cnt_en`  in  1  count enable; only effective with ENCT
- `dout`  out  WIDTH  read data, combinational mux selected by `instr`
- `addr`  out  WIDTH  address counter, always driven
- `done`  out  1  terminal-count / compare indication, combinational
- `halted`  out  1  auto-stop flag, registered

## Operation
- State:
  - `ctrl[3:0]`: `[1:0]` mode, `[2]` addr_dec, `[3]` auto_stop
  - `ar` (address reg), `ac` (address counter), `wcr` (word-count reg), `wc` (word counter), `halted`
- Instructions:
  - 0 WRCR: `ctrl<=din[3:0]`, `halted<=0`
  - 1 RDCR: `dout={0,ctrl}`
  - 2 RDWC: `dout=wc`
  - 3 RDAC: `dout=ac`
  - 4 REINIT: `ac<=ar`; `wc<=0` in modes 01/11, else `wc<=wcr`; `halted<=0`
  - 5 LDAD: `ar<=din`, `ac<=din`, `halted<=0`
  - 6 LDWC: `wcr<=din`; `wc<=0` in modes 01/11, else `wc<=din`; `halted<=0`
  - 7 ENCT: counting cycle
- `dout` = 0 for instructions 0 and 4–7.
- `cnt` = (`instr`==7) & `cnt_en` & !`halted`. When `cnt`=1, on the clock edge:
  - `ac` ±1 (−1 if addr_dec), wrapping mod 2^WIDTH
  - `wc`: mode 00 −1; modes 01/11 +1; mode 10 holds (compare value). All wrap mod 2^WIDTH.
- `done` (combinational):
  - mode 00: `cnt` ? `wc`==1 : `wc`==0
  - mode 01: `cnt` ? (`wc`+1 mod 2^WIDTH)==`wcr` : `wc`==`wcr`
  - mode 10: `wc`==`ac` (independent of `cnt`)
  - mode 11: 0
- Auto-stop: `halted<=1` at the edge where `cnt`=1, `done`=1 and auto_stop=1. While halted, ENCT does not count; `done` is evaluated with `cnt`=0.
- Priority within one cycle:
  - `rst` overrides everything.
  - Only one instruction exists per cycle, so loads and counting never coincide.
  - Clearing `halted` (WRCR/REINIT/LDAD/LDWC) takes effect the next cycle.
- A mode change via WRCR does not alter `wc`/`ac`. Only REINIT/LDWC apply the mode-dependent `wc` initialisation.

## Timing
- Reset (`rst`=1 at edge): all registers 0, so mode 00, increment, no auto-stop, `halted`=0.
- Outputs after reset: `addr`=0, `halted`=0. `dout`=0 unless `instr` is 1/2/3. `done`=1, because mode 00 with `wc`=0 and no count.
- Loads and counts: visible on `addr`/`dout`/`done` one cycle after the edge.
- `done` is same-cycle combinational from state, `instr` and `cnt_en`. It is asserted during the cycle in which the final count is executed (look-ahead), not after it.
- Reset mid-count: next cycle all state is 0; no partial update.

## Test plan
- Mode 00 countdown, WIDTH=8: LDWC 3, then ENCT with `cnt_en`=1 for 3 cycles.
  - `done`=0,0,1 during cycles 1–3; `wc`=0 afterwards.
  - With auto_stop=0, a 4th ENCT gives `wc`=0xFF and `done`=0.
- Mode 01 with auto_stop: WRCR 0x9, LDAD 0x10, LDWC 4, ENCT ×6.
  - `wc` 0→4 and `done`=1 in the 4th ENCT cycle; `halted`=1 afterwards.
  - `addr` stops at 0x14; `done` stays 1 (`wc`==`wcr`).
  - REINIT then gives `addr`=0x10, `wc`=0, `halted`=0.
- Address decrement wrap: WRCR 0x4, LDAD 0x01, ENCT ×2 → `addr`=0x00, then 0xFF.
- Mode 10 compare: WRCR 0x2, LDWC 0x23, LDAD 0x20, ENCT ×3 → `done` rises when `addr`=0x23; `wc` stays 0x23.
- Reads and `cnt_en`: RDCR/RDWC/RDAC return `ctrl`/`wc`/`ac`. ENCT with `cnt_en`=0 leaves all state unchanged, and mode 00 with `wc`=1 gives `done`=0.
- Reset mid-count: `rst` during an ENCT burst → next cycle `addr`=0, `halted`=0, `done`=1.
